// File: rtl/apb_pkg.sv
// Shared APB definitions for the requester and the slave memory.
// Holds the state encoding, default bus widths and the address limit.
// Also provides the timeout counter width helper.
package apb_pkg;

  // Transfer phase encoding shared by requester and slave
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int UPPER_ADDR_LIMIT   = 200;

  // Bits needed to hold TIMEOUT_CYCLES-1, never less than one bit
  function automatic int timeout_cnt_width(input int timeout_cycles);
    return (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS cycles spent with pready low and flags the terminating cycle.
// Latency: timeout_hit is combinational on pready and the registered count.
// Backpressure: none; the counter saturates at the terminating count.
module apb_timeout_counter
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic pready,
  output logic timeout_hit
);

  localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A ready slave always wins over the timeout on the same cycle
  assign timeout_hit = TIMEOUT_EN && !pready && (count_q == CNT_LAST);

  // Next count: clear on ACCESS entry, step only while waiting, hold at the limit
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (TIMEOUT_EN && enable && !pready && !timeout_hit) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB requester: one command per SETUP/ACCESS transfer, back-to-back capable.
// Latency: 2 cycles minimum plus one per wait state; response one cycle after completion.
// Backpressure: cmd_ready low during SETUP and waiting ACCESS; response cannot be stalled.
module apb_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_e            state_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;

  logic timeout_hit;
  logic done;
  logic accept;
  logic in_access;

  assign in_access = (state_q == ACCESS);
  assign done      = in_access && (pready || timeout_hit);
  assign cmd_ready = (state_q == IDLE) || done;
  assign accept    = cmd_valid && cmd_ready;

  // Bus strobes come straight from the state flop so the slave sees no input path
  assign psel    = (state_q != IDLE);
  assign penable = in_access;

  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (pclk),
    .rst        (preset),
    .clear      (state_q == SETUP),
    .enable     (in_access),
    .pready     (pready),
    .timeout_hit(timeout_hit)
  );

  // Transfer FSM with command capture and the one-cycle response register
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;

      if (accept) begin
        pwrite_q <= cmd_write;
        paddr_q  <= cmd_addr;
        pwdata_q <= cmd_wdata;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SETUP;
          end
        end
        SETUP: begin
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            rsp_valid_q   <= 1'b1;
            // pslverr only counts on a ready cycle; timeout_hit is already false then
            rsp_err_q     <= (pready && pslverr) || timeout_hit;
            rsp_timeout_q <= timeout_hit;
            rsp_rdata_q   <= (!pwrite_q && pready && !pslverr) ? prdata : '0;
            state_q       <= accept ? SETUP : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
APB requester that drives the bus side of the existing APB slave memory.
- Accepts single read/write commands on a valid/ready command port.
- Runs the APB SETUP/ACCESS sequence and waits on pready.
- Returns read data, slave error or timeout on a one-cycle response port.
- Sits between the test/CPU-side traffic source and the slave.

Parameters:
DATA_WIDTH, 8, width of pwdata/prdata/cmd_wdata/rsp_rdata
ADDR_WIDTH, 8, width of paddr/cmd_addr
TIMEOUT_CYCLES, 16, max ACCESS cycles with pready low before forced termination; 0 disables timeout

Ports:
pclk  input  1  clock, all logic on rising edge
preset  input  1  reset, synchronous, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_WIDTH  target address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  DATA_WIDTH  read data (0 on write or error)
rsp_err  output  1  pslverr or timeout
rsp_timeout  output  1  completion caused by timeout
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_WIDTH  APB address
pwdata  output  DATA_WIDTH  APB write data
prdata  input  DATA_WIDTH  slave read data
pready  input  1  slave ready
pslverr  input  1  slave error

Behaviour:
- Reset (preset=1 at edge): state IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err and rsp_timeout all 0; timeout counter 0.
- Reset overrides any transfer in progress: no response is issued and the aborted command is dropped.
- FSM states: IDLE, SETUP, ACCESS (2-bit).
- psel = (state != IDLE); penable = (state == ACCESS). Both are decoded from the state flop only, with no combinational input path.
- cmd_ready = (state == IDLE) | (state == ACCESS & done), where done = pready | timeout_hit.
- On accept, cmd_write/addr/wdata are captured into pwrite/paddr/pwdata. These hold stable through SETUP and ACCESS and keep their last values in IDLE.
- IDLE -> SETUP on accept, else stay in IDLE.
- SETUP -> ACCESS unconditionally, one cycle. The timeout counter clears on entry to ACCESS.
- ACCESS, done=0: stay; counter increments.
- ACCESS, done=1: completion. Next state is SETUP if a new command is accepted in the same cycle (back-to-back; psel stays 1, penable drops for one cycle), else IDLE.
- timeout_hit = (TIMEOUT_CYCLES != 0) & !pready & (count == TIMEOUT_CYCLES-1).
- Minimum transfer is 2 cycles (SETUP + one ACCESS). Each pready-low ACCESS cycle adds one cycle.
- The response is registered and appears on the cycle after completion:
  - rsp_valid=1 for exactly one cycle.
  - rsp_err = pslverr | timeout_hit.
  - rsp_timeout = timeout_hit.
  - rsp_rdata = prdata if read & pready & !pslverr, else 0.
  - rsp_valid=0 and rsp_rdata/rsp_err/rsp_timeout return to 0 on all other cycles.
- If pready and timeout_hit are both true, pready wins and timeout is not flagged. pslverr is sampled only when pready=1.
- The counter width is sized to hold TIMEOUT_CYCLES-1 and never wraps; it saturates at termination.
- No response backpressure; the consumer must accept rsp_valid every cycle.

Decomposition:
- apb_pkg: state encoding IDLE/SETUP/ACCESS, DATA_WIDTH/ADDR_WIDTH defaults, UPPER_ADDR_LIMIT=200, shared with the slave.
- Sub-module apb_timeout_counter:
  - Inputs: clear, enable, pready. Output: timeout_hit.
  - Parameterised by TIMEOUT_CYCLES.
- Everything else (FSM, capture registers, response register) stays in apb_master.

Test Plan:
- Write 0x10/0xA5, slave pready=1 immediately -> psel=1 for 2 cycles, penable=1 on 2nd only, pwrite=1, paddr=0x10, pwdata=0xA5; rsp_valid next cycle with rsp_err=0, rsp_rdata=0x00.
- Read 0x10, pready low for 3 ACCESS cycles then high with prdata=0xA5 -> ACCESS lasts 4 cycles, paddr stable; rsp_rdata=0xA5, rsp_err=0.
- cmd_valid held with write 0x20/0x3C then read 0x20, zero-wait slave -> psel stays 1 across both, penable pattern 0,1,0,1, no IDLE cycle, two rsp_valid pulses 2 cycles apart.
- Read with pready never asserted, TIMEOUT_CYCLES=16 -> ACCESS for exactly 16 cycles, then IDLE; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Read 0xF0 with slave returning pready=1, pslverr=1, prdata=0x77 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0x00.
- preset=1 during ACCESS -> next cycle psel=0, penable=0, cmd_ready=1, no rsp_valid ever for the aborted command.
